seq_det_ctrl: RTL and testbench
===============================

# seq_det_ctrl

Programmable, controller-wrapped serial sequence detector. It accepts a pattern configuration of up to MAXLEN bits through a ready/valid port and arms on `start`. While running it detects the pattern in a qualified serial bit stream in either overlapping or non-overlapping mode, and counts matches up to an optional target. It replaces hard-coded Mealy detectors wherever software or a host FSM must change the pattern at run time.

## Interface
Parameters:
- MAXLEN, 8: maximum pattern length in bits (2..16).
- CNTW, 8: width of the match counter and target.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready at a rising edge.
- cfg_pattern  in  MAXLEN  pattern bits; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  5  pattern length; legal range 1..MAXLEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNTW  match count that ends a run; 0 = run indefinitely.
- start  in  1  single-cycle pulse that begins or restarts a run.
- in_valid  in  1  qualifies `in`.
- in  in  1  serial data bit.
- out  out  1  Mealy match pulse, combinational.
- match_count  out  CNTW  matches counted in the current or last run.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

## Operation
- FSM states: IDLE, ARMED, RUN, DONE. Reset enters IDLE.
- IDLE:
  - cfg_ready = 1.
  - A handshake with a legal cfg_len latches pattern, len, overlap and target, then moves to ARMED.
  - A handshake with an illegal cfg_len (0 or > MAXLEN) is accepted and discarded; state stays IDLE.
  - start is ignored.
- ARMED:
  - cfg_ready = 1; a legal handshake reloads the config and the state stays ARMED. An illegal one is discarded.
  - start moves to RUN and clears the history, bit counter (seen) and match_count.
- RUN:
  - cfg_ready = 0.
  - Each cycle with in_valid = 1: history shifts left with `in` entering at LSB, and seen increments, saturating at MAXLEN.
  - Cycles with in_valid = 0 change nothing.
  - Match condition: in_valid && seen >= len-1 && the low len bits of {history, in} equal the low len bits of the pattern.
  - Non-overlap: on a match, seen clears to 0. History is left as is, but no new match can occur until len fresh bits have arrived.
  - Overlap: seen is untouched on a match.
  - Each match increments match_count, saturating at all-ones.
  - If target != 0 and the match brings match_count to target, the next state is DONE.
  - start in RUN restarts: history, seen and match_count are cleared. start wins over a simultaneous match, so that match is not counted. out still pulses combinationally.
- DONE:
  - match_count holds.
  - in is ignored and out = 0.
  - start moves to RUN with the same config and clears the counters.
  - cfg_ready = 1; a legal handshake moves to ARMED.
  - If start and a legal handshake occur in the same cycle, the handshake wins.

## Timing
- Reset values:
  - state IDLE, cfg_ready 1, out 0, match_count 0, busy 0, done 0.
  - Stored config: pattern 0, len 0, overlap 0, target 0.
- out has zero latency: it is high in the same cycle as the completing bit, and only while in RUN.
- match_count, busy and done update at the rising edge after the causing event.
- The RUN-to-DONE transition takes effect at the edge that counts the target match. done rises in the following cycle, with match_count == target.
- An asynchronous reset during RUN forces IDLE immediately. The config is lost and out drops in the same cycle.
- The config latches only at a handshake edge. Pattern bits above len are don't-care.

## Test plan
- Overlap, pattern 110, len 3, target 0. After start, drive stream 1,1,1,0,1,1,0,1,1,0,0,0,1,0 with in_valid = 1 throughout. Required: out pulses on bits 4, 7 and 10, and match_count = 3 at the end.
- Non-overlap, pattern 1101, len 4. Drive stream 1,1,0,1,1,0,1. Required: out pulses on bit 4 only, and match_count = 1. With overlap = 1, the same stream must give pulses on bits 4 and 7, and match_count = 2.
- Target stop: pattern 110, overlap, target 2, stream from test 1. Required: done = 1 in the cycle after bit 7, and match_count holds 2. Bits 8 onward produce no out pulses.
- in_valid gaps: pattern 101, with in_valid = 0 cycles between each valid bit while `in` toggles freely. Required: detection depends only on the qualified bits 1,0,1, and match_count = 1.
- Config rules:
  - A handshake with cfg_len = 0 in IDLE leaves the state in IDLE.
  - cfg_ready = 0 in RUN, and cfg_valid there has no effect.
  - A legal config in DONE leads to ARMED.
- Reset mid-run: assert reset after 2 matches. Required: out, match_count, busy and done are all 0 and cfg_ready = 1 immediately. start alone after reset must not enter RUN.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector with a config/arm/run/done controller.
// The pattern is loaded over a ready/valid port and matched against qualified input bits.
module seq_det_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNTW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [4:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in,
  output logic              out,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  state_e            state_q;
  logic [MAXLEN-1:0] pat_q;
  logic [4:0]        len_q;
  logic              ovl_q;
  logic [CNTW-1:0]   tgt_q;
  logic [MAXLEN-2:0] hist_q;
  logic [SW-1:0]     seen_q;

  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;
  logic              cfg_legal;
  logic              cfg_fire;
  logic              full_enough;
  logic              hit;
  logic [CNTW-1:0]   count_inc;
  logic [SW-1:0]     seen_inc;

  always_comb begin
    cfg_legal = (cfg_len != 5'd0) && (32'(cfg_len) <= MAXLEN);
    cfg_fire  = cfg_valid && cfg_ready;
    window    = {hist_q, in};
    mask      = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      mask[i] = (i < int'(len_q));
    end
    // At least len bits since start / last non-overlapping match, counting this one.
    full_enough = (32'(seen_q) + 32'd1) >= 32'(len_q);
    hit         = in_valid && full_enough && ((window & mask) == (pat_q & mask));
    out         = (state_q == StRun) && hit;
    count_inc   = (&match_count) ? match_count : match_count + CNTW'(1);
    seen_inc    = (32'(seen_q) < MAXLEN) ? seen_q + SW'(1) : seen_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      hist_q      <= '0;
      seen_q      <= '0;
      match_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_fire && cfg_legal) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            ovl_q   <= cfg_overlap;
            tgt_q   <= cfg_target;
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (cfg_fire && cfg_legal) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
          end
          if (start) begin
            hist_q      <= '0;
            seen_q      <= '0;
            match_count <= '0;
            state_q     <= StRun;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        StRun: begin
          if (start) begin
            // Restart takes priority; a coincident match is not counted.
            hist_q      <= '0;
            seen_q      <= '0;
            match_count <= '0;
          end else if (in_valid) begin
            hist_q <= window[MAXLEN-2:0];
            seen_q <= (hit && !ovl_q) ? '0 : seen_inc;
            if (hit) begin
              match_count <= count_inc;
              if ((tgt_q != '0) && (count_inc == tgt_q)) begin
                state_q   <= StDone;
                cfg_ready <= 1'b1;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          if (cfg_fire && cfg_legal) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            ovl_q   <= cfg_overlap;
            tgt_q   <= cfg_target;
            state_q <= StArmed;
            done    <= 1'b0;
          end else if (start) begin
            hist_q      <= '0;
            seen_q      <= '0;
            match_count <= '0;
            state_q     <= StRun;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a stream-level reference model predicts every out pulse
// and the controller status; a negedge monitor pops and compares out on qualified cycles.
module tb_seq_det_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [4:0]        cfg_len;
  logic              cfg_overlap;
  logic [CNTW-1:0]   cfg_target;
  logic              start;
  logic              in_valid;
  logic              in;
  logic              out;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;

  seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .start      (start),
    .in_valid   (in_valid),
    .in         (in),
    .out        (out),
    .match_count(match_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit exp_q[$];
  bit mon_e;

  // Reference model: 0 idle, 1 armed, 2 run, 3 done; the stream is kept as a list of bits.
  int         m_state;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_tgt;
  bit         m_bits[$];
  int         m_last;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pat = '0; m_len = 0; m_ovl = 1'b0; m_tgt = 0;
    m_bits.delete(); m_last = 0; m_cnt = 0;
  endtask

  task automatic model_clear_run();
    m_bits.delete(); m_last = 0; m_cnt = 0;
  endtask

  task automatic model_load(input logic [7:0] cp, input int cl, input bit co, input int ct);
    m_pat = cp; m_len = cl; m_ovl = co; m_tgt = ct;
  endtask

  // Last m_len stream bits equal the pattern (pattern bit 0 = newest), with enough fresh bits.
  function automatic bit model_hit();
    int n;
    n = m_bits.size();
    if (m_ovl ? (n < m_len) : (n - m_last < m_len)) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (m_bits[n-1-j] != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cycle(input bit cv, input logic [7:0] cp, input int cl, input bit co,
                       input int ct, input bit st, input bit v, input bit b);
    bit legal;
    bit hit;
    cfg_valid = cv; cfg_pattern = cp; cfg_len = 5'(cl); cfg_overlap = co;
    cfg_target = 8'(ct); start = st; in_valid = v; in = b;
    legal = cv && (cl >= 1) && (cl <= MAXLEN);
    hit = 1'b0;
    case (m_state)
      0: if (legal) begin model_load(cp, cl, co, ct); m_state = 1; end
      1: begin
        if (legal) model_load(cp, cl, co, ct);
        if (st) begin model_clear_run(); m_state = 2; end
      end
      2: begin
        if (v) begin m_bits.push_back(b); hit = model_hit(); end
        if (st) model_clear_run();
        else if (hit) begin
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) m_last = m_bits.size();
          if (m_tgt != 0 && m_cnt == m_tgt) m_state = 3;
        end
      end
      default: begin
        if (legal) begin model_load(cp, cl, co, ct); m_state = 1; end
        else if (st) begin model_clear_run(); m_state = 2; end
      end
    endcase
    if (v) exp_q.push_back(hit);
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input int l, input bit o, input int t);
    cycle(1'b1, p, l, o, t, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic go();
    cycle(1'b0, 8'h0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic bitv(input bit b);
    cycle(1'b0, 8'h0, 0, 1'b0, 0, 1'b0, 1'b1, b);
  endtask
  task automatic gap(input bit b);
    cycle(1'b0, 8'h0, 0, 1'b0, 0, 1'b0, 1'b0, b);
  endtask

  task automatic chk_status(input string name);
    chk({name, "_count"}, 32'(match_count), 32'(m_cnt));
    chk({name, "_busy"}, 32'(busy), 32'(m_state == 2));
    chk({name, "_done"}, 32'(done), 32'(m_state == 3));
    chk({name, "_cfg_ready"}, 32'(cfg_ready), 32'(m_state != 2));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (in_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual=%0b required=none", out);
        end else begin
          mon_e = exp_q.pop_front();
          if (out !== mon_e) begin
            errors++;
            $display("FAIL out actual=%0b required=%0b", out, mon_e);
          end
        end
      end else if (out !== 1'b0) begin
        errors++;
        $display("FAIL out_unqualified actual=%0b required=0", out);
      end
    end
  end

  bit t1[14] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0};
  bit t2[7]  = '{1, 1, 0, 1, 1, 0, 1};
  bit t5[8]  = '{1, 1, 0, 1, 1, 0, 1, 1};

  initial begin
    cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
    start = 0; in_valid = 0; in = 0;
    reset = 1'b1;
    model_reset();
    #3;
    chk_status("reset");
    chk("reset_out", 32'(out), 0);
    #9 reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Illegal lengths are discarded in IDLE; start alone is ignored there.
    cycle(1'b1, 8'h05, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk_status("idle_len0");
    cycle(1'b1, 8'h05, 9, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    go();
    chk_status("idle_start");

    // Overlap 110.
    cfg(8'b110, 3, 1'b1, 0);
    chk_status("armed");
    go();
    foreach (t1[i]) bitv(t1[i]);
    chk("t1_count", 32'(match_count), 3);
    chk_status("t1");

    // Config offered in RUN is refused and the old pattern stays active.
    chk("run_cfg_ready", 32'(cfg_ready), 0);
    cfg(8'b1, 1, 1'b1, 0);
    bitv(1); bitv(1); bitv(0);
    chk_status("run_cfg");

    do_reset();
    cfg(8'b1101, 4, 1'b0, 0);
    go();
    foreach (t2[i]) bitv(t2[i]);
    chk("t2_nonovl_count", 32'(match_count), 1);

    do_reset();
    cfg(8'b1101, 4, 1'b1, 0);
    go();
    foreach (t2[i]) bitv(t2[i]);
    chk("t2_ovl_count", 32'(match_count), 2);

    // Target stop after the second match.
    do_reset();
    cfg(8'b110, 3, 1'b1, 2);
    go();
    foreach (t1[i]) begin
      bitv(t1[i]);
      if (i == 6) begin
        chk("t3_done", 32'(done), 1);
        chk("t3_count", 32'(match_count), 2);
      end
    end
    chk_status("t3_end");

    cfg(8'b101, 3, 1'b0, 0);
    chk_status("done_cfg");

    // Qualified bits 1,0,1 with unqualified noise between them.
    go();
    bitv(1); gap(0); gap(1); bitv(0); gap(1); gap(0); bitv(1); gap(1);
    chk("t4_count", 32'(match_count), 1);

    // Asynchronous reset in the middle of a matching cycle.
    do_reset();
    cfg(8'b110, 3, 1'b1, 0);
    go();
    foreach (t5[i]) bitv(t5[i]);
    chk("t5_count", 32'(match_count), 2);
    mon_en = 1'b0;
    in_valid = 1'b1; in = 1'b0;
    #2;
    chk("t5_pre_reset_out", 32'(out), 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_out", 32'(out), 0);
    chk("t5_rst_count", 32'(match_count), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_cfg_ready", 32'(cfg_ready), 1);
    in_valid = 1'b0;
    #3 reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    mon_en = 1'b1;
    go();
    chk("t5_start_after_reset_busy", 32'(busy), 0);

    // Randomized runs with occasional restarts and config offers in every state.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      cfg(8'($urandom), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)));
      go();
      for (int c = 0; c < 100; c++) begin
        cycle(($urandom_range(0, 19) == 0), 8'($urandom), int'($urandom_range(0, 9)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 1)));
      end
      chk_status("rand");
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
